// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - memory byte bus and instruction slot signals of the fetch unit
interface inst_fetch_if;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_byte_i;
    logic        mem_byte_valid_i;
    logic        stall_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_byte_i,
        input  mem_byte_valid_i,
        input  stall_i,
        output inst_valid_o,
        output inst_o,
        output pc_o
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_byte_i,
        output mem_byte_valid_i,
        output stall_i,
        input  inst_valid_o,
        input  inst_o,
        input  pc_o
    );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - byte-serial instruction fetch with one output slot and one hold word
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          redirect_i,
    input  logic [31:0]   redirect_pc_i,
    inst_fetch_if.master  bus_if
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_out_q, pc_out_d;

    logic        accept;
    logic [31:0] word;

    assign accept = valid_q && !bus_if.stall_i;
    assign word   = {bus_if.mem_byte_i, buf_q[23:0]};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        hold_pc_d = hold_pc_q;
        valid_d   = valid_q;
        inst_d    = inst_q;
        pc_out_d  = pc_out_q;
        if (rdy_in) begin
            // A redirect overrides any byte, completion or acceptance in the same cycle.
            if (redirect_i) begin
                pc_d    = redirect_pc_i;
                cnt_d   = 2'd0;
                buf_d   = 32'h0;
                valid_d = 1'b0;
                state_d = S_FETCH;
            end else begin
                case (state_q)
                    S_IDLE: state_d = S_FETCH;
                    S_FETCH: begin
                        if (accept) valid_d = 1'b0;
                        if (bus_if.mem_byte_valid_i) begin
                            buf_d[{cnt_q, 3'b000} +: 8] = bus_if.mem_byte_i;
                            cnt_d = cnt_q + 2'd1;
                            if (cnt_q == 2'd3) begin
                                pc_d = pc_q + 32'd4;
                                if (!valid_q || accept) begin
                                    valid_d  = 1'b1;
                                    inst_d   = word;
                                    pc_out_d = pc_q;
                                end else begin
                                    buf_d     = word;
                                    hold_pc_d = pc_q;
                                    state_d   = S_HOLD;
                                end
                            end
                        end
                    end
                    S_HOLD: begin
                        if (accept) begin
                            valid_d  = 1'b1;
                            inst_d   = buf_q;
                            pc_out_d = hold_pc_q;
                            state_d  = S_FETCH;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            cnt_q     <= 2'd0;
            buf_q     <= 32'h0;
            hold_pc_q <= 32'h0;
            valid_q   <= 1'b0;
            inst_q    <= 32'h0;
            pc_out_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            hold_pc_q <= hold_pc_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            pc_out_q  <= pc_out_d;
        end
    end

    // cnt is always 0 outside FETCH, but the address is gated to pc there explicitly.
    assign bus_if.mem_req_o    = (state_q == S_FETCH);
    assign bus_if.mem_addr_o   = (state_q == S_FETCH) ? pc_q + {30'd0, cnt_q} : pc_q;
    assign bus_if.inst_valid_o = valid_q;
    assign bus_if.inst_o       = inst_q;
    assign bus_if.pc_o         = pc_out_q;
endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    int          n_cmp = 0;
    int          n_bad = 0;

    inst_fetch_if fi();

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .rdy_in        (rdy),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .bus_if        (fi)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mbyte(input logic [31:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return (lo * 8'd7) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] wexp(input logic [31:0] a);
        return {mbyte(a + 32'd3), mbyte(a + 32'd2), mbyte(a + 32'd1), mbyte(a)};
    endfunction

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; redirect = 1'b0;
        fi.mem_byte_valid_i = 1'b0; fi.stall_i = 1'b0; fi.mem_byte_i = 8'h0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            fi.mem_byte_i = mbyte(fi.mem_addr_o);
            fi.mem_byte_valid_i = 1'b1;
            @(negedge clk);
        end
        fi.mem_byte_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b0;
        fi.mem_byte_valid_i = 1'b1; fi.stall_i = 1'b0; fi.mem_byte_i = 8'h55;
        @(negedge clk);
        n_cmp++;
        if ({fi.inst_valid_o, fi.inst_o, fi.pc_o, fi.mem_req_o, fi.mem_addr_o} !== 98'h0) begin
            n_bad++;
            $display("FAIL reset_state: valid=%0b inst=%h pc=%h req=%0b addr=%h, required all 0",
                     fi.inst_valid_o, fi.inst_o, fi.pc_o, fi.mem_req_o, fi.mem_addr_o);
        end
        rst = 1'b0; rdy = 1'b1; fi.mem_byte_valid_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fi.mem_req_o !== 1'b1 || fi.mem_addr_o !== 32'h0) begin
            n_bad++;
            $display("FAIL first_req: req=%0b addr=%h, required 1 / 00000000", fi.mem_req_o, fi.mem_addr_o);
        end
    endtask

    task automatic test_first_word();
        logic [7:0] bytes [4];
        bytes[0] = 8'h13; bytes[1] = 8'h00; bytes[2] = 8'h00; bytes[3] = 8'h00;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (fi.mem_addr_o !== 32'(i) || fi.mem_req_o !== 1'b1 || fi.inst_valid_o !== 1'b0) begin
                n_bad++;
                $display("FAIL first_word_addr%0d: addr=%h req=%0b valid=%0b, required %h 1 0",
                         i, fi.mem_addr_o, fi.mem_req_o, fi.inst_valid_o, 32'(i));
            end
            fi.mem_byte_i = bytes[i]; fi.mem_byte_valid_i = 1'b1;
            @(negedge clk);
        end
        fi.mem_byte_valid_i = 1'b0;
        n_cmp++;
        if (fi.inst_valid_o !== 1'b1 || fi.inst_o !== 32'h13 || fi.pc_o !== 32'h0 || fi.mem_addr_o !== 32'h4) begin
            n_bad++;
            $display("FAIL first_word: valid=%0b inst=%h pc=%h addr=%h, required 1 00000013 00000000 00000004",
                     fi.inst_valid_o, fi.inst_o, fi.pc_o, fi.mem_addr_o);
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        fi.stall_i = 1'b1;
        feed(8);
        n_cmp++;
        if (fi.mem_req_o !== 1'b0 || fi.inst_valid_o !== 1'b1 || fi.pc_o !== 32'h0 || fi.inst_o !== wexp(32'h0)) begin
            n_bad++;
            $display("FAIL hold_enter: req=%0b valid=%0b pc=%h inst=%h, required 0 1 00000000 %h",
                     fi.mem_req_o, fi.inst_valid_o, fi.pc_o, fi.inst_o, wexp(32'h0));
        end
        feed(3);
        n_cmp++;
        if (fi.mem_req_o !== 1'b0 || fi.pc_o !== 32'h0 || fi.mem_addr_o !== 32'h8) begin
            n_bad++;
            $display("FAIL hold_stay: req=%0b pc=%h addr=%h, required 0 00000000 00000008",
                     fi.mem_req_o, fi.pc_o, fi.mem_addr_o);
        end
        fi.stall_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fi.inst_valid_o !== 1'b1 || fi.pc_o !== 32'h4 || fi.inst_o !== wexp(32'h4) ||
            fi.mem_req_o !== 1'b1 || fi.mem_addr_o !== 32'h8) begin
            n_bad++;
            $display("FAIL hold_release: valid=%0b pc=%h inst=%h req=%0b addr=%h, required 1 00000004 %h 1 00000008",
                     fi.inst_valid_o, fi.pc_o, fi.inst_o, fi.mem_req_o, fi.mem_addr_o, wexp(32'h4));
        end
        @(negedge clk);
        n_cmp++;
        if (fi.inst_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL accept_clear: valid=%0b, required 0", fi.inst_valid_o);
        end
    endtask

    task automatic test_redirect_mid();
        do_reset();
        feed(2);
        redirect = 1'b1; redirect_pc = 32'h100;
        fi.mem_byte_i = 8'hEE; fi.mem_byte_valid_i = 1'b1;
        @(negedge clk);
        redirect = 1'b0; fi.mem_byte_valid_i = 1'b0;
        n_cmp++;
        if (fi.mem_addr_o !== 32'h100 || fi.mem_req_o !== 1'b1 || fi.inst_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL redirect_mid: addr=%h req=%0b valid=%0b, required 00000100 1 0",
                     fi.mem_addr_o, fi.mem_req_o, fi.inst_valid_o);
        end
        feed(4);
        n_cmp++;
        if (fi.inst_valid_o !== 1'b1 || fi.pc_o !== 32'h100 || fi.inst_o !== wexp(32'h100)) begin
            n_bad++;
            $display("FAIL redirect_word: valid=%0b pc=%h inst=%h, required 1 00000100 %h",
                     fi.inst_valid_o, fi.pc_o, fi.inst_o, wexp(32'h100));
        end
    endtask

    task automatic test_redirect_completion();
        do_reset();
        fi.stall_i = 1'b1;
        feed(7);
        redirect = 1'b1; redirect_pc = 32'h200;
        fi.mem_byte_i = mbyte(fi.mem_addr_o); fi.mem_byte_valid_i = 1'b1;
        @(negedge clk);
        redirect = 1'b0; fi.mem_byte_valid_i = 1'b0;
        n_cmp++;
        if (fi.inst_valid_o !== 1'b0 || fi.mem_req_o !== 1'b1 || fi.mem_addr_o !== 32'h200) begin
            n_bad++;
            $display("FAIL redirect_complete: valid=%0b req=%0b addr=%h, required 0 1 00000200",
                     fi.inst_valid_o, fi.mem_req_o, fi.mem_addr_o);
        end
        fi.stall_i = 1'b0;
        feed(4);
        n_cmp++;
        if (fi.inst_valid_o !== 1'b1 || fi.pc_o !== 32'h200 || fi.inst_o !== wexp(32'h200)) begin
            n_bad++;
            $display("FAIL redirect_complete_word: valid=%0b pc=%h inst=%h, required 1 00000200 %h",
                     fi.inst_valid_o, fi.pc_o, fi.inst_o, wexp(32'h200));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        feed(4);
        n_cmp++;
        if (fi.inst_valid_o !== 1'b1 || fi.pc_o !== 32'hFFFF_FFFC || fi.inst_o !== wexp(32'hFFFF_FFFC) ||
            fi.mem_addr_o !== 32'h0) begin
            n_bad++;
            $display("FAIL wrap: valid=%0b pc=%h inst=%h addr=%h, required 1 fffffffc %h 00000000",
                     fi.inst_valid_o, fi.pc_o, fi.inst_o, fi.mem_addr_o, wexp(32'hFFFF_FFFC));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fi.stall_i = 1'b1;
        feed(6);
        rst = 1'b1;
        fi.mem_byte_i = 8'h77; fi.mem_byte_valid_i = 1'b1;
        @(negedge clk);
        fi.mem_byte_valid_i = 1'b0;
        n_cmp++;
        if ({fi.inst_valid_o, fi.inst_o, fi.pc_o, fi.mem_req_o, fi.mem_addr_o} !== 98'h0) begin
            n_bad++;
            $display("FAIL reset_mid: valid=%0b inst=%h pc=%h req=%0b addr=%h, required all 0",
                     fi.inst_valid_o, fi.inst_o, fi.pc_o, fi.mem_req_o, fi.mem_addr_o);
        end
        rst = 1'b0; fi.stall_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fi.mem_req_o !== 1'b1 || fi.mem_addr_o !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mid_restart: req=%0b addr=%h, required 1 00000000", fi.mem_req_o, fi.mem_addr_o);
        end
    endtask

    task automatic test_rdy_freeze();
        do_reset();
        feed(2);
        rdy = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
        fi.mem_byte_i = 8'hCC; fi.mem_byte_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (fi.mem_addr_o !== 32'h2 || fi.inst_valid_o !== 1'b0 || fi.mem_req_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rdy_freeze: addr=%h valid=%0b req=%0b, required 00000002 0 1",
                     fi.mem_addr_o, fi.inst_valid_o, fi.mem_req_o);
        end
        rdy = 1'b1; redirect = 1'b0; fi.mem_byte_valid_i = 1'b0;
        feed(2);
        n_cmp++;
        if (fi.inst_valid_o !== 1'b1 || fi.pc_o !== 32'h0 || fi.inst_o !== wexp(32'h0)) begin
            n_bad++;
            $display("FAIL rdy_resume: valid=%0b pc=%h inst=%h, required 1 00000000 %h",
                     fi.inst_valid_o, fi.pc_o, fi.inst_o, wexp(32'h0));
        end
    endtask

    // Reference: accepted instructions form the sequential stream from the last redirect target.
    task automatic test_random();
        logic [31:0] exp_pc;
        int          delivered;
        do_reset();
        exp_pc = 32'h0;
        delivered = 0;
        for (int c = 0; c < 4000; c++) begin
            rdy                 = ($urandom_range(0, 9) != 0);
            fi.stall_i          = ($urandom_range(0, 9) < 3);
            fi.mem_byte_valid_i = ($urandom_range(0, 9) < 7);
            redirect            = ($urandom_range(0, 99) < 3);
            redirect_pc         = ($urandom_range(0, 3) == 0) ? $urandom : {20'h0, 10'($urandom), 2'b00};
            fi.mem_byte_i       = mbyte(fi.mem_addr_o);
            if (rdy) begin
                if (redirect) begin
                    exp_pc = redirect_pc;
                end else if (fi.inst_valid_o && !fi.stall_i) begin
                    n_cmp++;
                    if (fi.pc_o !== exp_pc || fi.inst_o !== wexp(exp_pc)) begin
                        n_bad++;
                        $display("FAIL random_deliver@%0d: pc=%h inst=%h, required %h %h",
                                 c, fi.pc_o, fi.inst_o, exp_pc, wexp(exp_pc));
                    end
                    exp_pc = exp_pc + 32'd4;
                    delivered++;
                end
            end
            @(negedge clk);
        end
        redirect = 1'b0; rdy = 1'b1; fi.mem_byte_valid_i = 1'b0; fi.stall_i = 1'b0;
        n_cmp++;
        if (delivered < 50) begin
            n_bad++;
            $display("FAIL random_progress: delivered=%0d, required at least 50", delivered);
        end
    endtask

    initial begin
        fi.mem_byte_i = 8'h0; fi.mem_byte_valid_i = 1'b0; fi.stall_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_first_word();
        test_stall_hold();
        test_redirect_mid();
        test_redirect_completion();
        test_wrap();
        test_reset_mid();
        test_rdy_freeze();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, meaning: PC of the first fetch after reset.
REQ-002 clk_in  input  1  meaning: the single clock; all state updates on its rising edge.
REQ-003 rst_in  input  1  meaning: reset, synchronous and active-high.
REQ-004 rdy_in  input  1  meaning: global ready; 0 freezes all state.
REQ-005 redirect_i  input  1  meaning: jump or branch taken; the fetch stream restarts at redirect_pc_i.
REQ-006 redirect_pc_i  input  32  meaning: new PC for a redirect.
REQ-007 stall_i  input  1  meaning: decode cannot accept the presented instruction this cycle.
REQ-008 mem_req_o  output  1  meaning: byte read request to MEMCTRL.
REQ-009 mem_addr_o  output  32  meaning: byte address requested.
REQ-010 mem_byte_i  input  8  meaning: returned byte.
REQ-011 mem_byte_valid_i  input  1  meaning: mem_byte_i is valid for the current mem_addr_o.
REQ-012 inst_valid_o  output  1  meaning: inst_o and pc_o hold a valid instruction for IF_ID.
REQ-013 inst_o  output  32  meaning: assembled instruction word.
REQ-014 pc_o  output  32  meaning: address of inst_o.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH and HOLD; IDLE SHALL be entered only by reset and SHALL go to FETCH on the next cycle.
REQ-016 Internal state SHALL comprise fetch PC pc, a 2-bit byte counter cnt, a 32-bit assembly buffer buf, and an output slot (inst_valid_o/inst_o/pc_o).
REQ-017 In FETCH, mem_req_o SHALL be 1 and mem_addr_o SHALL equal pc+cnt; in IDLE and HOLD, mem_req_o SHALL be 0 and mem_addr_o SHALL equal pc.
REQ-018 On each edge in FETCH with mem_byte_valid_i=1, the design SHALL store mem_byte_i into buf[8*cnt+7:8*cnt] (little-endian) and increment cnt.
REQ-019 Word completion is cnt=3 with mem_byte_valid_i=1; at that edge cnt SHALL become 0 and pc SHALL become pc+4, modulo 2^32.
REQ-020 A slot is accepted at an edge where inst_valid_o=1 and stall_i=0; without a new load, acceptance SHALL clear inst_valid_o.
REQ-021 At completion, if the slot is empty or accepted at the same edge, the word SHALL load into the slot (inst_valid_o=1, pc_o=old pc) and the state SHALL remain FETCH.
REQ-022 At completion, if the slot is full and not accepted, the word SHALL be kept in buf with its pc and the state SHALL go to HOLD.
REQ-023 In HOLD, on slot acceptance, buf and its pc SHALL load into the slot with inst_valid_o=1, and the state SHALL return to FETCH.
REQ-024 Latency: inst_valid_o SHALL rise on the edge that captures the fourth byte, so it is visible in the cycle after that byte is presented.
REQ-025 On redirect_i=1 (and rdy_in=1), at the next edge:
  - pc SHALL be set to redirect_pc_i and cnt to 0;
  - inst_valid_o SHALL be cleared, and any HOLD word and partial buf SHALL be discarded;
  - the state SHALL become FETCH.
REQ-026 A redirect SHALL take priority over a simultaneous byte arrival, completion, stall, or acceptance; the byte SHALL be dropped.
REQ-027 redirect_pc_i SHALL be used unmodified; no alignment is applied.
REQ-028 With rdy_in=0, all registers SHALL hold, and redirect_i and mem_byte_valid_i SHALL be ignored.
REQ-029 Outputs SHALL be driven only from registers, except mem_addr_o, which is the combinational sum pc+cnt.

Reset
REQ-030 On an edge with rst_in=1, regardless of rdy_in or of any fetch in progress:
  - state SHALL be set to IDLE, pc to RESET_PC, cnt to 0, and buf to 0;
  - inst_valid_o, inst_o and pc_o SHALL be set to 0.
REQ-031 After reset, the first mem_req_o=1 SHALL occur one cycle after rst_in deasserts, with mem_addr_o=RESET_PC.

Verification
REQ-032 Reset, then bytes 13,00,00,00 valid on consecutive cycles -> mem_addr_o 0,1,2,3; next cycle inst_valid_o=1, inst_o=32'h00000013, pc_o=0; mem_addr_o=4.
REQ-033 Continuous stall_i=1 with continuous byte supply -> word0 in slot, word1 in HOLD, mem_req_o=0; release stall_i -> pc_o 0 then 4 delivered on successive acceptances, fetch resumes at 8.
REQ-034 redirect_i=1 with redirect_pc_i=32'h100 while cnt=2 -> next mem_addr_o=32'h100; no instruction with pc_o=0 is delivered.
REQ-035 redirect_i coincident with the fourth byte and a valid, unaccepted slot -> inst_valid_o=0 next cycle and state=FETCH; neither the slot word nor the completed word is ever delivered.
REQ-036 redirect_pc_i=32'hFFFFFFFC followed by 4 bytes -> pc_o=32'hFFFFFFFC, then mem_addr_o=0.
REQ-037 rst_in=1 during FETCH with cnt=2 and a valid slot -> next cycle all outputs 0; fetch restarts at RESET_PC.
